// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle for the fetch unit.
// master: fetch unit (issues requests); slave: instruction memory.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage and program counter for the MIPS231 single-cycle core.
// Requests a word over the imem req/ack bundle, latches it, strobes exec for one
// cycle, then advances the PC according to pcsel.
// Optional feature macro: FETCH_TIMEOUT_EN (fetch watchdog with sticky fault).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [1:0]         pcsel,
    input  logic [31:0]        rs_data,
    fetch_unit_if.master       imem,
    output logic [31:0]        instr,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic               exec,
    output logic               fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
`ifdef FETCH_TIMEOUT_EN
        ,
        FAULT = 2'd3
`endif
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        req_c;
    logic        exec_c;
    logic [31:0] next_pc;

    // Low two bits of the JR target are forced to zero.
    logic        unused_bits;
    assign unused_bits = ^{rs_data[1:0], (TIMEOUT != 0)};

`ifdef FETCH_TIMEOUT_EN
    // Counter only needs to hold 0..TIMEOUT-1: the cycle that would reach
    // TIMEOUT goes straight to FAULT instead of storing the value.
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;
`endif

    assign pc_plus4       = pc + 32'd4;
    assign imem.imem_req  = req_c;
    assign imem.imem_addr = pc;
    assign exec           = exec_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore outputs
    always_comb begin
        state_next = state;
        req_c      = 1'b0;
        exec_c     = 1'b0;
        case (state)
            IDLE: begin
                if (run) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                req_c = 1'b1;
                if (imem.imem_ack) begin
                    state_next = EXEC;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (wait_cnt == CNT_LAST) begin
                    state_next = FAULT;
                end
`endif
            end
            EXEC: begin
                exec_c     = 1'b1;
                state_next = run ? FETCH : IDLE;
            end
`ifdef FETCH_TIMEOUT_EN
            FAULT: begin
                state_next = FAULT;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Next-PC selection from pcsel and the latched instruction
    always_comb begin
        next_pc = pc_plus4;
        case (pcsel)
            2'b00: next_pc = pc_plus4;
            2'b01: next_pc = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
            2'b10: next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
            2'b11: next_pc = {rs_data[31:2], 2'b00};
            default: next_pc = pc_plus4;
        endcase
    end

    // Instruction latch on accepted ack; PC update at the end of EXEC
    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= RESET_PC;
            instr <= '0;
        end else begin
            if (state == FETCH && imem.imem_ack) begin
                instr <= imem.imem_rdata;
            end
            if (state == EXEC) begin
                pc <= next_pc;
            end
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Wait counter: cleared on entry to FETCH, counts FETCH cycles without ack
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state != FETCH) begin
            wait_cnt <= '0;
        end else if (!imem.imem_ack && wait_cnt != CNT_LAST) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // FAULT is absorbing until reset, so the flag is sticky by construction
    always_comb begin
        fault = (state == FAULT);
    end
`else
    assign fault = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage and program counter for the MIPS231 single-cycle core. It sits directly upstream of the control unit. It requests instructions from instruction memory over a req/ack handshake and latches the returned word. It then raises a one-cycle execute strobe that drives the control unit's write enable, and computes the next PC from the control unit's `pcsel` plus the latched instruction.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `TIMEOUT`, 16, max cycles in FETCH without `imem_ack` before fault (used only with `FETCH_TIMEOUT_EN`).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `run`  in  1  processor run request; low parks the FSM in IDLE after the current instruction.
- `pcsel`  in  2  next-PC select from the control unit: 00 seq, 01 branch, 10 jump, 11 JR.
- `rs_data`  in  32  register-file rs read value (JR target).
- `imem_req`  out  1  instruction memory request.
- `imem_addr`  out  32  instruction memory address (= `pc`).
- `imem_ack`  in  1  instruction memory response valid.
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`.
- `instr`  out  32  latched instruction (op = [31:26], func = [5:0] to the control unit).
- `pc`  out  32  current PC.
- `pc_plus4`  out  32  `pc + 4` (JAL link value), combinational.
- `exec`  out  1  execute strobe; connects to the control unit's `enable`.
- `fault`  out  1  sticky fetch-timeout flag (constant 0 without `FETCH_TIMEOUT_EN`).

## Operation
- Reset values:
  - state IDLE, `pc`=`RESET_PC`, `instr`=0.
  - `imem_req`=0, `exec`=0, `fault`=0, timeout counter 0.
- States: IDLE, FETCH, EXEC, FAULT.
  - IDLE: `imem_req`=0, `exec`=0. If `run`=1, go to FETCH; else stay.
  - FETCH: `imem_req`=1, `imem_addr`=`pc` held stable until ack. On `imem_ack`, `instr`<=`imem_rdata` and go to EXEC; else stay.
  - EXEC: `exec`=1 for exactly this cycle. At the edge, `pc`<=`next_pc`. Go to FETCH if `run`=1, else IDLE.
  - FAULT: exists only with the macro. `imem_req`=0, `exec`=0, `fault`=1. Exits only via reset.
- `next_pc`, all arithmetic 32-bit modulo 2^32 (wrap silently):
  - 00: `pc_plus4`.
  - 01: `pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}`.
  - 10: `{pc_plus4[31:28], instr[25:0], 2'b00}`.
  - 11: `{rs_data[31:2], 2'b00}` (low bits forced to zero).
- `pcsel` and `rs_data` are sampled only in EXEC; they are ignored in all other states.
- `imem_ack` outside FETCH is ignored, including a late ack arriving after reset.
- `instr` is updated only on an accepted ack. `pc` is updated only at the end of EXEC.
- `run` deasserted during FETCH takes effect only after that instruction's EXEC; no fetch is abandoned.

## Timing
- Minimum 2 cycles per instruction: FETCH with same-cycle ack, then EXEC. Each wait cycle without ack adds 1.
- `instr` and `pc` are stable during the whole EXEC cycle. The new `pc` is visible the cycle after EXEC, coinciding with the next FETCH request.
- IDLE→FETCH takes 1 cycle after `run` is seen high.
- Reset asserted in any state: at the next edge, all reset values apply and any outstanding request is dropped. Reset overrides `imem_ack` and the EXEC PC update.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A counter clears on entry to FETCH and increments each FETCH cycle without ack.
  - When it reaches `TIMEOUT` without ack, the FSM enters FAULT and `fault` latches to 1.
  - An ack in the cycle the count would reach `TIMEOUT` wins: the FSM goes to EXEC with no fault.
- Undefined: no counter, no FAULT state, FETCH waits indefinitely, `fault` tied to 0.

## Test plan
- Reset then `run`=1, memory acks same cycle with `pcsel`=00: `imem_addr` sequence is 0x0, 0x4, 0x8, `exec` pulses every 2nd cycle, and `pc_plus4`=0x4 during the first EXEC.
- `pc`=0x100, `instr`=BEQ with imm 16'hFFFE, `pcsel`=01: next `imem_addr`=0xFC. With imm 16'h0003: next `imem_addr`=0x110.
- `pc`=0x8000_0010, J with `instr[25:0]`=26'h0000040: next `imem_addr`=0x8000_0100. JR with `rs_data`=0x1237: next `imem_addr`=0x1234.
- `imem_ack` delayed 3 cycles: `imem_req` and `imem_addr` held constant 3 cycles, `exec` stays 0 until the ack, a spurious ack in EXEC or IDLE leaves `instr` unchanged, and `run` dropped mid-FETCH produces one more EXEC and then IDLE.
- With `FETCH_TIMEOUT_EN`, `TIMEOUT`=16, no ack: `fault`=1 after 16 FETCH cycles, `imem_req`=0 thereafter, and reset clears it. An ack on cycle 16 yields EXEC with no fault.
- `pc`=0xFFFF_FFFC, `pcsel`=00: next `pc`=0x0000_0000. Reset asserted during FETCH: next cycle `imem_req`=0 and `pc`=`RESET_PC`.
